gray_counter: RTL and testbench



---
 rtl/gray_pkg.sv | 17 +
 rtl/gray_counter.sv | 81 ++++++++
 tb/tb_gray_counter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter: default width, direction
// encoding and the binary-to-Gray helper.
package gray_pkg;

  localparam int unsigned GRAY_W = 32;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Binary to reflected Gray code at the full default width.
  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage : gray_pkg

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with synchronous load and wrap/change pulses.
// Keeps a binary count and registers its Gray encoding alongside it.
// Optional build macro GRAY_CNT_SAT_EN: saturate at the count limits
// instead of wrapping; wrap then flags a saturation hit.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned W = GRAY_W
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         en,
  input  logic         dir,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] gray,
  output logic         chg,
  output logic         wrap
);

  localparam logic [W-1:0] BIN_MAX  = {W{1'b1}};
  localparam logic [W-1:0] BIN_ZERO = '0;
  localparam logic [W-1:0] BIN_ONE  = W'(1);

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;
  logic         chg_q, chg_d;
  logic         wrap_q, wrap_d;
  logic         at_limit;

  // W-bit view of the shared helper; zero-extension keeps the MSB exact.
  function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
    return W'(bin2gray(GRAY_W'(b)));
  endfunction

  // Next count, Gray word and pulses: load beats enable, enable steps by dir.
  always_comb begin
    bin_d    = bin_q;
    gray_d   = gray_q;
    chg_d    = 1'b0;
    wrap_d   = 1'b0;
    at_limit = (dir_t'(dir) == DIR_UP) ? (bin_q == BIN_MAX) : (bin_q == BIN_ZERO);
    if (ld) begin
      bin_d  = ld_val;
      gray_d = to_gray(ld_val);
      chg_d  = (gray_d != gray_q);
    end else if (en) begin
      wrap_d = at_limit;
`ifdef GRAY_CNT_SAT_EN
      if (!at_limit) begin
        bin_d = (dir_t'(dir) == DIR_UP) ? bin_q + BIN_ONE : bin_q - BIN_ONE;
        chg_d = 1'b1;
      end
`else
      bin_d = (dir_t'(dir) == DIR_UP) ? bin_q + BIN_ONE : bin_q - BIN_ONE;
      chg_d = 1'b1;
`endif
      gray_d = to_gray(bin_d);
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bin_q  <= '0;
      gray_q <= '0;
      chg_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      chg_q  <= chg_d;
      wrap_q <= wrap_d;
    end
  end

  assign gray = gray_q;
  assign chg  = chg_q;
  assign wrap = wrap_q;

endmodule : gray_counter

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (W=32): directed boundary cases plus
// randomized traffic checked against an arithmetic model of the count.
module tb_gray_counter;

  localparam int unsigned W = 32;
  localparam logic [W-1:0] MAX = {W{1'b1}};
`ifdef GRAY_CNT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nrst;
  logic         en, dir, ld;
  logic [W-1:0] ld_val;
  logic [W-1:0] gray;
  logic         chg, wrap;

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  logic [W-1:0] mb;

  gray_counter #(.W(W)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .en     (en),
    .dir    (dir),
    .ld     (ld),
    .ld_val (ld_val),
    .gray   (gray),
    .chg    (chg),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Gray word built bit by bit from neighbouring binary bits.
  function automatic logic [W-1:0] gray_of(input logic [W-1:0] b);
    logic [W-1:0] g;
    for (int i = 0; i < W - 1; i++) g[i] = b[i] ^ b[i+1];
    g[W-1] = b[W-1];
    return g;
  endfunction

  // Gray back to binary by running XOR from the MSB down.
  function automatic logic [W-1:0] bin_of(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // One clock: drive at negedge, sample after posedge, advance model, compare.
  task automatic step(input logic e, input logic d, input logic l, input logic [W-1:0] v);
    logic [W-1:0] nb, pg;
    logic ew, ec, stepped, limit;
    @(negedge clk);
    en = e; dir = d; ld = l; ld_val = v;
    @(posedge clk);
    #1;
    nb = mb; ew = 1'b0; ec = 1'b0; stepped = 1'b0;
    if (l) begin
      nb = v;
      ec = (gray_of(v) != gray_of(mb));
    end else if (e) begin
      limit = d ? (mb == MAX) : (mb == '0);
      ew = limit;
      if (!(limit && SAT)) begin
        nb = d ? mb + 1 : mb - 1;
        ec = 1'b1;
        stepped = 1'b1;
      end
    end
    pg = gray_of(mb);
    mb = nb;
    check_eq("gray", 64'(gray), 64'(gray_of(mb)));
    check_eq("chg", 64'(chg), 64'(ec));
    check_eq("wrap", 64'(wrap), 64'(ew));
    check_eq("g2b", 64'(bin_of(gray)), 64'(mb));
    if (stepped) check_eq("one_bit", 64'($countones(gray ^ pg)), 64'd1);
  endtask

  initial begin
    logic [W-1:0] v;
    int unsigned  r;
    nrst = 1'b0; en = 1'b0; dir = 1'b1; ld = 1'b0; ld_val = '0;
    mb = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gray", 64'(gray), 64'd0);
    check_eq("rst_chg", 64'(chg), 64'd0);
    check_eq("rst_wrap", 64'(wrap), 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Count to bin=5, then reset asynchronously between edges.
    repeat (5) step(1'b1, 1'b1, 1'b0, '0);
    check_eq("pre_rst_gray", 64'(gray), 64'h7);
    en = 1'b0;
    #2;
    nrst = 1'b0;
    #1;
    mb = '0;
    check_eq("async_gray", 64'(gray), 64'd0);
    check_eq("async_chg", 64'(chg), 64'd0);
    check_eq("async_wrap", 64'(wrap), 64'd0);
    @(posedge clk);
    #1;
    check_eq("held_gray", 64'(gray), 64'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Gray sequence after release.
    step(1'b1, 1'b1, 1'b0, '0); check_eq("seq1", 64'(gray), 64'h1);
    step(1'b1, 1'b1, 1'b0, '0); check_eq("seq2", 64'(gray), 64'h3);
    step(1'b1, 1'b1, 1'b0, '0); check_eq("seq3", 64'(gray), 64'h2);
    step(1'b1, 1'b1, 1'b0, '0); check_eq("seq4", 64'(gray), 64'h6);

    // Hold for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i[0], 1'b0, '0);
      check_eq("hold_gray", 64'(gray), 64'h6);
    end

    // Up wrap.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE); check_eq("upw_ld", 64'(gray), 64'h8000_0001);
    step(1'b1, 1'b1, 1'b0, '0);
    check_eq("upw_max", 64'(gray), 64'h8000_0000);
    check_eq("upw_max_wrap", 64'(wrap), 64'd0);
    step(1'b1, 1'b1, 1'b0, '0);
    check_eq("upw_wrap", 64'(wrap), 64'd1);
    check_eq("upw_gray", 64'(gray), SAT ? 64'h8000_0000 : 64'h0);
    check_eq("upw_chg", 64'(chg), SAT ? 64'd0 : 64'd1);

    // Down wrap.
    step(1'b0, 1'b0, 1'b1, 32'h1); check_eq("dnw_ld", 64'(gray), 64'h1);
    step(1'b1, 1'b0, 1'b0, '0);
    check_eq("dnw_zero", 64'(gray), 64'h0);
    check_eq("dnw_zero_wrap", 64'(wrap), 64'd0);
    step(1'b1, 1'b0, 1'b0, '0);
    check_eq("dnw_wrap", 64'(wrap), 64'd1);
    check_eq("dnw_gray", 64'(gray), SAT ? 64'h0 : 64'h8000_0000);
    check_eq("dnw_chg", 64'(chg), SAT ? 64'd0 : 64'd1);

    // Load beats enable; reloading the same value leaves gray unchanged.
    step(1'b1, 1'b1, 1'b1, 32'hA);
    check_eq("ldp_gray", 64'(gray), 64'hF);
    check_eq("ldp_wrap", 64'(wrap), 64'd0);
    step(1'b1, 1'b0, 1'b1, 32'hA);
    check_eq("ldsame_chg", 64'(chg), 64'd0);
    check_eq("ldsame_gray", 64'(gray), 64'hF);

    // Random traffic with loads biased toward the count boundaries.
    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 9);
      case ($urandom_range(0, 5))
        0: v = '0;
        1: v = MAX;
        2: v = MAX - 1;
        3: v = 32'h1;
        4: v = mb;
        default: v = $urandom;
      endcase
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'(r == 0), v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gray_counter
